// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: size codes, ls_op bit positions, FSM states.
package lsu_ctrl_pkg;

    localparam logic [1:0] LS_ILL  = 2'b00;
    localparam logic [1:0] LS_BYTE = 2'b01;
    localparam logic [1:0] LS_HALF = 2'b10;
    localparam logic [1:0] LS_WORD = 2'b11;

    localparam int unsigned LS_EN = 3;
    localparam int unsigned LS_ST = 2;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StWait = 2'b10
    } lsu_state_e;

    // Byte-enable pattern for lane 0 before shifting by the byte offset.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            LS_BYTE: size_mask = 4'b0001;
            LS_HALF: size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: offset alignment, byte enables, store replication, load extract.
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic [1:0]  off_eff,
    output logic [3:0]  be,
    output logic [31:0] st_data,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_sign,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        // Misaligned halves/words snap down to their natural boundary.
        off_eff = off;
        case (size)
            LS_HALF: off_eff[0] = 1'b0;
            LS_WORD: off_eff    = 2'b00;
            default: ;
        endcase
        be = size_mask(size) << off_eff;
        case (size)
            LS_BYTE: st_data = {4{wdata[7:0]}};
            LS_HALF: st_data = {2{wdata[15:0]}};
            default: st_data = wdata;
        endcase
    end

    always_comb begin
        shifted = rdata >> {ld_off, 3'b000};
        case (ld_size)
            LS_BYTE: ld_data = {{24{ld_sign & shifted[7]}}, shifted[7:0]};
            LS_HALF: ld_data = {{16{ld_sign & shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit with a single-outstanding req/gnt/rvalid data port.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of force-aligning.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned AW   = 32,
    parameter int unsigned RD_W = 5
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic [3:0]      ls_op,
    input  logic            ls_sign,
    input  logic [AW-1:0]   ls_addr,
    input  logic [31:0]     ls_wdata,
    input  logic [RD_W-1:0] ls_rd,
    input  logic            ls_flush,
    output logic            lsu_busy,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [AW-1:0]   dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [31:0]     dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [31:0]     dmem_rdata,
    output logic            lsu_wb_vld,
    output logic [RD_W-1:0] lsu_wb_rd,
    output logic [31:0]     lsu_wb_data,
    output logic            lsu_misalign
);

    lsu_state_e state_q, state_d;

    logic            st_q, st_d;
    logic [1:0]      size_q, size_d;
    logic [1:0]      off_q, off_d;
    logic            sign_q, sign_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic            kill_q, kill_d;

    logic            req_d, we_d, wb_vld_d, misalign_d;
    logic [AW-1:0]   addr_d;
    logic [3:0]      be_d;
    logic [31:0]     wdata_d, wb_data_d;
    logic [RD_W-1:0] wb_rd_d;

    logic [1:0]      off_eff;
    logic [3:0]      al_be;
    logic [31:0]     al_st_data, al_ld_data;
    logic            op_valid, misalign, accept;

    lsu_align u_align (
        .size    (ls_op[1:0]),
        .off     (ls_addr[1:0]),
        .wdata   (ls_wdata),
        .off_eff (off_eff),
        .be      (al_be),
        .st_data (al_st_data),
        .ld_size (size_q),
        .ld_off  (off_q),
        .ld_sign (sign_q),
        .rdata   (dmem_rdata),
        .ld_data (al_ld_data)
    );

    assign op_valid = ls_op[LS_EN] && (ls_op[1:0] != LS_ILL) && !ls_flush;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = op_valid && (off_eff != ls_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign accept = (state_q == StIdle) && op_valid && !misalign;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StReq;
            StReq: begin
                if (dmem_gnt)      state_d = StWait;
                else if (ls_flush) state_d = StIdle;
            end
            StWait:  if (dmem_rvalid) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        lsu_busy   = (state_q != StIdle) || accept;
        req_d      = dmem_req;
        we_d       = dmem_we;
        addr_d     = dmem_addr;
        be_d       = dmem_be;
        wdata_d    = dmem_wdata;
        wb_vld_d   = 1'b0;
        wb_rd_d    = lsu_wb_rd;
        wb_data_d  = lsu_wb_data;
        misalign_d = 1'b0;
        st_d       = st_q;
        size_d     = size_q;
        off_d      = off_q;
        sign_d     = sign_q;
        rd_d       = rd_q;
        kill_d     = kill_q;
        unique case (state_q)
            StIdle: begin
                misalign_d = misalign;
                if (accept) begin
                    req_d   = 1'b1;
                    we_d    = ls_op[LS_ST];
                    addr_d  = {ls_addr[AW-1:2], 2'b00};
                    be_d    = al_be;
                    wdata_d = al_st_data;
                    st_d    = ls_op[LS_ST];
                    size_d  = ls_op[1:0];
                    off_d   = off_eff;
                    sign_d  = ls_sign;
                    rd_d    = ls_rd;
                    kill_d  = 1'b0;
                end
            end
            StReq: begin
                if (dmem_gnt) begin
                    req_d  = 1'b0;
                    kill_d = ls_flush;
                end else if (ls_flush) begin
                    req_d = 1'b0;
                end
            end
            StWait: begin
                if (ls_flush) kill_d = 1'b1;
                // A flushed access still consumes its response but never writes back.
                if (dmem_rvalid && !st_q && !kill_q && !ls_flush) begin
                    wb_vld_d  = 1'b1;
                    wb_rd_d   = rd_q;
                    wb_data_d = al_ld_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= '0;
            dmem_wdata   <= '0;
            lsu_wb_vld   <= 1'b0;
            lsu_wb_rd    <= '0;
            lsu_wb_data  <= '0;
            lsu_misalign <= 1'b0;
            st_q         <= 1'b0;
            size_q       <= LS_ILL;
            off_q        <= 2'b00;
            sign_q       <= 1'b0;
            rd_q         <= '0;
            kill_q       <= 1'b0;
        end else begin
            dmem_req     <= req_d;
            dmem_we      <= we_d;
            dmem_addr    <= addr_d;
            dmem_be      <= be_d;
            dmem_wdata   <= wdata_d;
            lsu_wb_vld   <= wb_vld_d;
            lsu_wb_rd    <= wb_rd_d;
            lsu_wb_data  <= wb_data_d;
            lsu_misalign <= misalign_d;
            st_q         <= st_d;
            size_q       <= size_d;
            off_q        <= off_d;
            sign_q       <= sign_d;
            rd_q         <= rd_d;
            kill_q       <= kill_d;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases then random transactions vs a byte-level model.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    localparam int unsigned AW   = 32;
    localparam int unsigned RD_W = 5;

    logic            CLK = 1'b0;
    logic            RSTN = 1'b0;
    logic [3:0]      ls_op = '0;
    logic            ls_sign = 1'b0;
    logic [AW-1:0]   ls_addr = '0;
    logic [31:0]     ls_wdata = '0;
    logic [RD_W-1:0] ls_rd = '0;
    logic            ls_flush = 1'b0;
    logic            lsu_busy;
    logic            dmem_req, dmem_we;
    logic [AW-1:0]   dmem_addr;
    logic [3:0]      dmem_be;
    logic [31:0]     dmem_wdata;
    logic            dmem_gnt = 1'b0;
    logic            dmem_rvalid = 1'b0;
    logic [31:0]     dmem_rdata = '0;
    logic            lsu_wb_vld;
    logic [RD_W-1:0] lsu_wb_rd;
    logic [31:0]     lsu_wb_data;
    logic            lsu_misalign;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    lsu_ctrl #(.AW(AW), .RD_W(RD_W)) dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .ls_op        (ls_op),
        .ls_sign      (ls_sign),
        .ls_addr      (ls_addr),
        .ls_wdata     (ls_wdata),
        .ls_rd        (ls_rd),
        .ls_flush     (ls_flush),
        .lsu_busy     (lsu_busy),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .lsu_wb_vld   (lsu_wb_vld),
        .lsu_wb_rd    (lsu_wb_rd),
        .lsu_wb_data  (lsu_wb_data),
        .lsu_misalign (lsu_misalign)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: access covers nb consecutive bytes starting at the aligned offset.
    function automatic int nbytes(input logic [1:0] size);
        return (size == LS_BYTE) ? 1 : (size == LS_HALF) ? 2 : 4;
    endfunction

    function automatic int eff_off(input logic [1:0] size, input logic [1:0] off);
        int nb = nbytes(size);
        return int'(off) - (int'(off) % nb);
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] size, input int eo);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (i >= eo) && (i < eo + nbytes(size));
        return r;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nbytes(size)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_ld(input logic [1:0] size, input int eo, input logic sign,
                                           input logic [31:0] rd);
        logic [31:0] v;
        int nb = nbytes(size);
        v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = rd[8*(eo + i) +: 8];
        if (sign && nb < 4 && v[8*nb-1])
            for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    // fmode: 0 normal, 1 flush in REQ before gnt, 2 flush with rvalid, 3 flush with gnt
    task automatic run_txn(input logic st, input logic [1:0] size, input logic sign,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                           input int gdly, input int rdly, input logic [31:0] rdat, input int fmode);
        int eo;
        logic wb;
        eo = eff_off(size, addr[1:0]);
        @(negedge CLK);
        ls_op = {1'b1, st, size};
        ls_sign = sign;
        ls_addr = addr;
        ls_wdata = wd;
        ls_rd = rd;
        #1;
`ifdef LSU_MISALIGN_TRAP_EN
        if (eo != int'(addr[1:0])) begin
            check("mis_busy", lsu_busy, 1'b0);
            @(negedge CLK);
            check("mis_pulse", lsu_misalign, 1'b1);
            check("mis_noreq", dmem_req, 1'b0);
            ls_op = '0;
            @(negedge CLK);
            check("mis_pulse_end", lsu_misalign, 1'b0);
            check("mis_noreq2", dmem_req, 1'b0);
            return;
        end
`endif
        check("acc_busy", lsu_busy, 1'b1);
        for (int k = 0; k <= gdly; k++) begin
            @(negedge CLK);
            check("req", dmem_req, 1'b1);
            check("addr", dmem_addr, {addr[31:2], 2'b00});
            check("be", {28'd0, dmem_be}, {28'd0, exp_be(size, eo)});
            check("we", dmem_we, st);
            if (st) check("wdata", dmem_wdata, exp_wd(size, wd));
            if (k == 0) check("no_misalign", lsu_misalign, 1'b0);
            ls_addr = $urandom;
            ls_wdata = $urandom;
            ls_rd = 5'($urandom);
            if (fmode == 1) begin
                ls_flush = 1'b1;
                ls_op = '0;
                @(negedge CLK);
                ls_flush = 1'b0;
                check("flush_req_drop", dmem_req, 1'b0);
                #1 check("flush_req_busy", lsu_busy, 1'b0);
                @(negedge CLK);
                check("flush_req_nowb", lsu_wb_vld, 1'b0);
                return;
            end
            dmem_gnt = (k == gdly);
            if (fmode == 3 && k == gdly) ls_flush = 1'b1;
            #1 check("req_busy", lsu_busy, 1'b1);
        end
        for (int j = 0; j <= rdly; j++) begin
            @(negedge CLK);
            dmem_gnt = 1'b0;
            ls_flush = 1'b0;
            check("wait_noreq", dmem_req, 1'b0);
            check("wait_nowb", lsu_wb_vld, 1'b0);
            dmem_rvalid = (j == rdly);
            dmem_rdata = (j == rdly) ? rdat : $urandom;
            if (fmode == 2 && j == rdly) ls_flush = 1'b1;
            #1 check("wait_busy", lsu_busy, 1'b1);
        end
        @(negedge CLK);
        dmem_rvalid = 1'b0;
        ls_flush = 1'b0;
        ls_op = '0;
        wb = !st && (fmode == 0);
        check("wb_vld", lsu_wb_vld, wb);
        if (wb) begin
            check("wb_data", lsu_wb_data, exp_ld(size, eo, sign, rdat));
            check("wb_rd", {27'd0, lsu_wb_rd}, {27'd0, rd});
        end
        #1 check("done_busy", lsu_busy, 1'b0);
        @(negedge CLK);
        check("wb_pulse_end", lsu_wb_vld, 1'b0);
    endtask

    initial begin
        #12;
        check("rst_req", dmem_req, 1'b0);
        check("rst_we", dmem_we, 1'b0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_be", {28'd0, dmem_be}, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_wb_vld", lsu_wb_vld, 1'b0);
        check("rst_wb_rd", {27'd0, lsu_wb_rd}, 32'd0);
        check("rst_wb_data", lsu_wb_data, 32'd0);
        check("rst_misalign", lsu_misalign, 1'b0);
        check("rst_busy", lsu_busy, 1'b0);
        @(negedge CLK);
        RSTN = 1'b1;

        run_txn(1'b1, LS_WORD, 1'b0, 32'h104, 32'hDEADBEEF, 5'd1, 0, 0, 32'h0, 0);
        run_txn(1'b0, LS_BYTE, 1'b1, 32'h203, 32'h0, 5'd7, 0, 0, 32'h80112233, 0);
        run_txn(1'b0, LS_HALF, 1'b0, 32'h202, 32'h0, 5'd9, 0, 0, 32'h9ABC1234, 0);
        run_txn(1'b1, LS_BYTE, 1'b0, 32'h11, 32'h000000A5, 5'd3, 3, 1, 32'h0, 0);
        run_txn(1'b0, LS_WORD, 1'b0, 32'h300, 32'h0, 5'd4, 2, 0, 32'h12345678, 1);
        run_txn(1'b0, LS_WORD, 1'b0, 32'h304, 32'h0, 5'd5, 0, 2, 32'h87654321, 2);
        run_txn(1'b0, LS_HALF, 1'b1, 32'h306, 32'h0, 5'd6, 1, 0, 32'hFFFF0000, 3);
        run_txn(1'b0, LS_BYTE, 1'b0, 32'h401, 32'h0, 5'd0, 0, 0, 32'h0000C300, 0);
        run_txn(1'b0, LS_WORD, 1'b0, 32'h102, 32'h0, 5'd2, 0, 0, 32'hCAFEF00D, 0);

        // Illegal size and an op blocked by flush must not start an access.
        @(negedge CLK);
        ls_op = {1'b1, 1'b0, LS_ILL};
        #1 check("ill_busy", lsu_busy, 1'b0);
        @(negedge CLK);
        check("ill_noreq", dmem_req, 1'b0);
        ls_op = {1'b1, 1'b0, LS_WORD};
        ls_flush = 1'b1;
        #1 check("flush_idle_busy", lsu_busy, 1'b0);
        @(negedge CLK);
        check("flush_idle_noreq", dmem_req, 1'b0);
        ls_op = '0;
        ls_flush = 1'b0;

        // Reset while waiting for a response.
        ls_op = {1'b1, 1'b0, LS_WORD};
        ls_addr = 32'h500;
        ls_rd = 5'd8;
        @(negedge CLK);
        dmem_gnt = 1'b1;
        @(negedge CLK);
        dmem_gnt = 1'b0;
        ls_op = '0;
        RSTN = 1'b0;
        #1;
        check("midrst_busy", lsu_busy, 1'b0);
        check("midrst_req", dmem_req, 1'b0);
        @(negedge CLK);
        RSTN = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h11111111;
        @(negedge CLK);
        dmem_rvalid = 1'b0;
        check("midrst_nowb", lsu_wb_vld, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic [1:0] sz;
            int fm;
            sz = 2'($urandom_range(1, 3));
            fm = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            run_txn(1'($urandom), sz, 1'($urandom), $urandom, $urandom, 5'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom, fm);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
